// File: rtl/instr_mem_pipelined_if.sv
// Fetch/response/load bus between the fetch stage and the pipelined instruction memory.
interface instr_mem_pipelined_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) ();
  localparam int LOAD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [1:0]            rsp_fault;
  logic                  load_en;
  logic [LOAD_W-1:0]     load_addr;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  flush;

  modport master (
    output req_valid, req_addr, rsp_ready, load_en, load_addr, load_data, flush,
    input  req_ready, rsp_valid, rsp_data, rsp_fault
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready, load_en, load_addr, load_data, flush,
    output req_ready, rsp_valid, rsp_data, rsp_fault
  );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Synchronous instruction memory: one-cycle fetch into a 2-entry response FIFO,
// runtime program load, flush, and misaligned/out-of-range fault tagging.
module instr_mem_pipelined #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_mem_pipelined_if.slave  bus
);
  localparam int OFS    = $clog2(DATA_WIDTH / 8);
  localparam int LOAD_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [DATA_WIDTH-1:0] ent_data  [2];
  logic [1:0]            ent_fault [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;

  logic                  accept;
  logic                  pop;
  logic                  ready;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  load_ok;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [DATA_WIDTH-1:0] fetch_data;
  logic [1:0]            fetch_fault;

  always_comb begin
    ready        = !reset && !bus.load_en && !bus.flush && (count < 2'd2);
    accept       = bus.req_valid && ready;
    pop          = (count != 2'd0) && bus.rsp_ready;
    word_idx     = bus.req_addr >> OFS;
    misaligned   = |bus.req_addr[OFS-1:0];
    out_of_range = word_idx >= ADDR_WIDTH'(DEPTH);
    fetch_fault  = {out_of_range, misaligned};
    fetch_data   = '0;
    if (!misaligned && !out_of_range)
      fetch_data = mem[word_idx[LOAD_W-1:0]];
    load_ok      = {1'b0, bus.load_addr} < (LOAD_W + 1)'(DEPTH);
  end

  // Array has no reset so a loaded program survives Reset.
  always_ff @(posedge clk) begin
    if (bus.load_en && load_ok)
      mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      count        <= 2'd0;
      wr_ptr       <= 1'b0;
      rd_ptr       <= 1'b0;
      ent_data[0]  <= '0;
      ent_data[1]  <= '0;
      ent_fault[0] <= 2'b00;
      ent_fault[1] <= 2'b00;
    end else begin
      if (accept) begin
        ent_data[wr_ptr]  <= fetch_data;
        ent_fault[wr_ptr] <= fetch_fault;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs are gated to zero when empty so reset shows RspData=0.
  always_comb begin
    bus.req_ready = ready;
    bus.rsp_valid = (count != 2'd0);
    bus.rsp_data  = '0;
    bus.rsp_fault = 2'b00;
    if (count != 2'd0) begin
      bus.rsp_data  = ent_data[rd_ptr];
      bus.rsp_fault = ent_fault[rd_ptr];
    end
  end
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed plus randomized bench for instr_mem_pipelined against a queue-based reference.
module tb_instr_mem_pipelined;
  localparam int AW    = 64;
  localparam int DW    = 32;
  localparam int DEPTH = 256;
  localparam int LW    = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instr_mem_pipelined_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  instr_mem_pipelined #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [1:0]    fault;
  } rsp_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] mem_m [DEPTH];
  rsp_t          q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t expect_rsp(input logic [AW-1:0] addr);
    rsp_t          r;
    logic [AW-1:0] idx;
    idx       = addr / (DW / 8);
    r.fault   = {idx >= AW'(DEPTH), (addr % (DW / 8)) != 0};
    r.data    = (r.fault != 2'b00) ? '0 : mem_m[idx[LW-1:0]];
    return r;
  endfunction

  task automatic drive(input logic rv, input logic [AW-1:0] addr, input logic rr,
                       input logic le, input logic [LW-1:0] la, input logic [DW-1:0] ld,
                       input logic fl, input logic rs);
    bus.req_valid = rv;
    bus.req_addr  = addr;
    bus.rsp_ready = rr;
    bus.load_en   = le;
    bus.load_addr = la;
    bus.load_data = ld;
    bus.flush     = fl;
    reset         = rs;
  endtask

  // One clock: compare outputs with the model mid-cycle, then advance the model at the edge.
  task automatic cycle();
    logic exp_ready, acc, pp;
    rsp_t r;
    @(negedge clk);
    exp_ready = !reset && !bus.load_en && !bus.flush && (q.size() < 2);
    chk("req_ready", bus.req_ready, exp_ready);
    chk("rsp_valid", bus.rsp_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("rsp_data", bus.rsp_data, q[0].data);
      chk("rsp_fault", bus.rsp_fault, q[0].fault);
    end
    acc = bus.req_valid && exp_ready;
    pp  = (q.size() != 0) && bus.rsp_ready;
    r   = expect_rsp(bus.req_addr);
    @(posedge clk);
    if (reset || bus.flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(r);
    end
    if (bus.load_en) mem_m[bus.load_addr] = bus.load_data;
    #1;
  endtask

  initial begin
    logic [DW-1:0] prog [4];
    int            kind;
    logic [AW-1:0] a;
    prog[0] = 32'hAA1F03F4;
    prog[1] = 32'hF8400289;
    prog[2] = 32'hF840828A;
    prog[3] = 32'hF841028B;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

    drive(1'b1, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
    #1;
    cycle();
    cycle();
    chk("reset_valid", bus.rsp_valid, 1'b0);
    chk("reset_data", bus.rsp_data, '0);
    chk("reset_fault", bus.rsp_fault, 2'b00);
    chk("reset_ready", bus.req_ready, 1'b0);

    for (int i = 0; i < 4; i++) begin
      drive(1'b1, '0, 1'b1, 1'b1, LW'(i), prog[i], 1'b0, 1'b0);
      cycle();
    end

    // back-to-back fetch with consumer always ready
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(i * 4), 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
      cycle();
      chk("b2b_data", bus.rsp_data, prog[i]);
    end
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("b2b_drained", bus.rsp_valid, 1'b0);

    // backpressure: two accepts then stall
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, AW'(i * 4), 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
      cycle();
    end
    chk("bp_hold_data", bus.rsp_data, 32'hAA1F03F4);
    chk("bp_full_ready", bus.req_ready, 1'b0);
    drive(1'b1, 64'h8, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("bp_second", bus.rsp_data, 32'hF8400289);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("bp_third", bus.rsp_data, 32'hF840828A);
    cycle();

    // fault decode
    drive(1'b1, 64'h6, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("mis_fault", bus.rsp_fault, 2'b01);
    chk("mis_data", bus.rsp_data, '0);
    drive(1'b1, 64'h400, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("oor_fault", bus.rsp_fault, 2'b10);
    drive(1'b1, 64'h402, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("both_fault", bus.rsp_fault, 2'b11);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // flush a full buffer
    drive(1'b1, 64'h0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("flush_valid", bus.rsp_valid, 1'b0);
    drive(1'b1, 64'hC, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("post_flush", bus.rsp_data, 32'hF841028B);

    // load has priority; the next-cycle fetch sees the new word
    drive(1'b1, 64'h8, 1'b1, 1'b1, 8'd2, 32'h8B0901AD, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'h8, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("load_fwd", bus.rsp_data, 32'h8B0901AD);
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();

    // reset with a full buffer keeps the array
    drive(1'b1, 64'h4, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 64'h4, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1);
    cycle();
    chk("rst_mid_valid", bus.rsp_valid, 1'b0);
    chk("rst_mid_data", bus.rsp_data, '0);
    drive(1'b1, 64'h0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("rst_retain", bus.rsp_data, 32'hAA1F03F4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 9));
      if (kind < 7)       a = AW'($urandom_range(0, 15) * 4);
      else if (kind == 7) a = AW'($urandom_range(0, 63));
      else if (kind == 8) a = {32'($urandom), 32'($urandom)};
      else                a = AW'($urandom_range(1020, 1040));
      drive(1'($urandom_range(0, 3) != 0), a, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 9) == 0), LW'($urandom_range(0, 15)), DW'($urandom),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 59) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
